// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage and its PC register.
package if_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_RESET  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  // What the fetch stage does at the next edge when not in reset.
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_act_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: synchronous reset, hold enable and word-aligned target load.
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = PC_RESET
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  assign pc4_o = pc_q + PC_INC;

  // NOTE: pc_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    pc_d = pc_q;
    if (load_i)       pc_d = word_align(load_pc_i);
    else if (!hold_i) pc_d = pc4_o;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch address and IF/ID register with redirect/stall/flush.
// Optional performance counters enabled by defining IF_STAGE_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = PC_RESET,
  parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] instruction,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic [XLEN-1:0] if_id_instr,
`ifdef IF_STAGE_PERF_CNT_EN
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] stall_cnt,
`endif
  output logic            if_id_valid
);

  fetch_act_e      act;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] if_id_pc4_q, if_id_instr_q;
  logic            if_id_valid_q;

  // Redirect beats stall: the instruction held in ID is on the wrong path.
  always_comb begin
    act = ACT_ADVANCE;
    if (redirect)   act = ACT_REDIRECT;
    else if (stall) act = ACT_STALL;
  end

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .hold_i    (act == ACT_STALL),
    .load_i    (act == ACT_REDIRECT),
    .load_pc_i (redirect_pc),
    .pc_o      (PC),
    .pc4_o     (pc4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_pc4_q   <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
    end else begin
      case (act)
        ACT_REDIRECT: begin
          if_id_pc4_q   <= '0;
          if_id_instr_q <= NOP_INSTR;
          if_id_valid_q <= 1'b0;
        end
        ACT_ADVANCE: begin
          if_id_pc4_q   <= pc4;
          if_id_instr_q <= instruction;
          if_id_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (act == ACT_ADVANCE) fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (act == ACT_STALL)   stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed test-plan sequence followed by random stall/redirect/reset traffic.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, instruction, PC;
  logic [31:0] if_id_pc4, if_id_instr;
  logic        if_id_valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] fcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t model;

  always #5 clk = ~clk;

  // Pseudo-random ROM contents so every address carries a distinct word.
  function automatic logic [31:0] rom(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  assign instruction = rom(PC);

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .PC          (PC),
    .instruction (instruction),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
`ifdef IF_STAGE_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .if_id_valid (if_id_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: after each edge, compare the DUT state against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", PC, e.pc);
      check("if_id_pc4", if_id_pc4, e.pc4);
      check("if_id_instr", if_id_instr, e.instr);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
`ifdef IF_STAGE_PERF_CNT_EN
      check("fetch_cnt", fetch_cnt, e.fcnt);
      check("stall_cnt", stall_cnt, e.scnt);
`endif
    end
  end

  // Drive one cycle of inputs and push the state the stage must hold after the next edge.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
    @(negedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = tgt;
    if (r) begin
      model = '{pc: 32'h0, pc4: 32'h0, instr: 32'h0, valid: 1'b0, fcnt: 32'h0, scnt: 32'h0};
    end else if (rd) begin
      model.pc    = tgt & ~32'd3;
      model.pc4   = 32'h0;
      model.instr = 32'h0;
      model.valid = 1'b0;
    end else if (s) begin
      model.scnt = model.scnt + 1;
    end else begin
      model.instr = rom(model.pc);
      model.pc    = model.pc + 4;
      model.pc4   = model.pc;
      model.valid = 1'b1;
      model.fcnt  = model.fcnt + 1;
    end
    exp_q.push_back(model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model = '{pc: 32'h0, pc4: 32'h0, instr: 32'h0, valid: 1'b0, fcnt: 32'h0, scnt: 32'h0};

    step(1, 0, 0, 0);                       // reset state
    step(0, 0, 0, 0); step(0, 0, 0, 0);     // PC 4, 8
    repeat (3) step(0, 1, 0, 0);            // stall at PC=8
    step(0, 0, 0, 0);                       // PC 12, IF/ID holds PC=8 word
    step(0, 0, 1, 32'h40);                  // redirect flush
    step(0, 0, 0, 0);                       // target word, pc4=0x44
    step(0, 1, 1, 32'h20);                  // redirect beats stall
    step(0, 0, 1, 32'h23);                  // misaligned target
    step(0, 0, 1, 32'hFFFF_FFFF);           // PC=FFFF_FFFC
    step(0, 0, 0, 0);                       // wrap to 0, pc4=0
    step(0, 0, 1, 32'h40);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);                       // reset mid-run with stall
    step(0, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           $urandom());
    end

    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
